sa_sequencer: RTL and testbench
===============================

Name: sa_sequencer

Overview:
Job-level controller for the 4x4 systolic array. Packs nibble-serial host data into 8-bit weights and activations and writes them into the array. Then clears accumulators, enables compute for a fixed cycle count, and streams the accumulator results back out, byte-serial, over a valid/ready interface. Sits between the chip pin wrapper and the systolic array core.

Parameters:
- N, 4, array dimension (N x N PEs, N*N weights, N*N activations, N*N results)
- DATA_W, 8, weight/activation width; fixed at 2 nibbles
- ACC_W, 16, accumulator width; must be a multiple of 8
- COMPUTE_CYCLES, 3*N-2, cycles arr_compute_en is held high (skewed fill + drain)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin job; honoured only in IDLE
- keep_w  in  1  sampled with start; 1 = skip LOAD_W and reuse resident weights
- abort  in  1  synchronous abort, any state
- host_nib  in  4  host nibble, low nibble of each byte first
- host_valid  in  1  host nibble valid
- host_ready  out  1  high in LOAD_W/LOAD_X
- arr_data  out  DATA_W  packed byte to array
- arr_addr  out  $clog2(N*N)  element index, row-major (row = idx/N, col = idx%N)
- arr_load_w  out  1  one-cycle weight write strobe
- arr_load_x  out  1  one-cycle activation write strobe
- arr_clear  out  1  one-cycle accumulator clear
- arr_compute_en  out  1  compute enable
- arr_res_sel  out  $clog2(N*N)  result select
- arr_res  in  ACC_W  selected accumulator, combinational from array
- res_out  out  8  result byte
- res_valid  out  1  res_out valid
- res_ready  in  1  consumer ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset: state IDLE; all outputs 0; all counters 0; nibble half-flag cleared.
- FSM: IDLE -> LOAD_W, or LOAD_X if keep_w -> CLEAR -> COMPUTE -> READOUT -> IDLE.
- IDLE: start=1 moves to LOAD_W/LOAD_X next cycle. host_valid in IDLE is ignored; no state change.
- Nibble accept: host_valid && host_ready. The first nibble is latched as the low half; the second completes the byte.
- Write latency: the byte completes on cycle t. On cycle t+1, arr_data = {hi,lo}, arr_addr = byte index, and arr_load_w (LOAD_W) or arr_load_x (LOAD_X) is high for exactly 1 cycle.
- Load transition: after 2*N*N accepted nibbles, the state advances on the cycle the final write strobe is issued. host_ready drops that cycle. The half-flag and index reset between phases.
- CLEAR: arr_clear high for 1 cycle.
- COMPUTE: arr_compute_en high for exactly COMPUTE_CYCLES consecutive cycles, then READOUT.
- READOUT: ACC_W/8 bytes per element. Elements go in order 0..N*N-1, LSB byte first.
  - arr_res_sel = current element; res_out = arr_res[8k+7:8k], registered.
  - res_valid holds and res_out stays stable until res_ready. The next byte is presented the cycle after a handshake, with no bubble.
- Completion: after the last byte handshake, done pulses 1 cycle and the state is IDLE in that same cycle. busy is low there.
- start while busy: ignored.
- abort: highest priority, over start and over a same-cycle handshake. Next cycle: IDLE, all strobes and res_valid low, counters cleared, no done. Array contents are undefined to the host afterwards.
- rst_n low mid-job: same as reset; it takes precedence over abort.
- Partial nibble at abort: discarded.

Decomposition:
- Package sa_pkg holds:
  - state enum (IDLE, LOAD_W, LOAD_X, CLEAR, COMPUTE, READOUT)
  - default N, DATA_W, ACC_W
  - localparams NUM_ELEM = N*N, IDX_W, BYTES_PER_RES = ACC_W/8
- Sub-module sa_nibble_packer: half-flag plus low-nibble register. It emits a byte and a one-cycle byte_valid, with a synchronous clear used on phase change and abort.

Test Plan:
- Identity job, N=4, ACC_W=16: weights = identity matrix, activations 1..16, start.
  - Expect 16 arr_load_w strobes, then 16 arr_load_x strobes with addresses 0..15.
  - Expect 1 arr_clear, then arr_compute_en high exactly 10 cycles.
  - Expect output bytes 01 00 02 00 ... 10 00, then done pulsed once.
- Backpressure: same job with res_ready toggled 1-0-0-1 repeating -> no byte lost or duplicated; res_out stable while stalled; 32 handshakes total.
- keep_w=1 with a second activation set 2..17 -> no arr_load_w strobes; results 02 00 ... 11 00.
- Abort after 7 nibbles of LOAD_X -> next cycle busy=0, host_ready=0, no done. A new full job afterwards gives correct results, with the stale half-nibble not used.
- start pulsed during COMPUTE and READOUT -> ignored; exactly one done per job.
- rst_n low during READOUT with res_valid=1 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic-array job sequencer.
package sa_pkg;

  localparam int N_DEF      = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int NIB_W      = 4;
  localparam int BYTE_W     = 2 * NIB_W;

  localparam int NUM_ELEM      = N_DEF * N_DEF;
  localparam int IDX_W         = $clog2(NUM_ELEM);
  localparam int BYTES_PER_RES = ACC_W_DEF / 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_X,
    CLEAR,
    COMPUTE,
    READOUT
  } state_t;

endpackage

// File: rtl/sa_nibble_packer.sv
// Assembles two host nibbles (low first) into a byte with a one-cycle valid.
module sa_nibble_packer
  import sa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              nib_valid,
  input  logic [NIB_W-1:0]  nib,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid
);

  logic             half;
  logic [NIB_W-1:0] lo;

  // clr drops any half-assembled byte so a stale low nibble never leaks forward
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half       <= 1'b0;
      lo         <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else if (clr) begin
      half       <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= nib_valid && half;
      if (nib_valid) begin
        if (half) byte_data <= {nib, lo};
        else      lo        <= nib;
        half <= !half;
      end
    end
  end

endmodule

// File: rtl/sa_sequencer.sv
// Job controller: loads weights/activations nibble-serially, runs the array,
// then streams accumulators out byte-serially over valid/ready.
module sa_sequencer
  import sa_pkg::*;
#(
  parameter int N              = N_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ACC_W          = ACC_W_DEF,
  parameter int COMPUTE_CYCLES = 3 * N - 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    keep_w,
  input  logic                    abort,
  input  logic [3:0]              host_nib,
  input  logic                    host_valid,
  output logic                    host_ready,
  output logic [DATA_W-1:0]       arr_data,
  output logic [$clog2(N*N)-1:0]  arr_addr,
  output logic                    arr_load_w,
  output logic                    arr_load_x,
  output logic                    arr_clear,
  output logic                    arr_compute_en,
  output logic [$clog2(N*N)-1:0]  arr_res_sel,
  input  logic [ACC_W-1:0]        arr_res,
  output logic [7:0]              res_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int ELEMS = N * N;
  localparam int AW    = $clog2(N * N);
  localparam int BPR   = ACC_W / 8;
  localparam int BW    = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int CW    = $clog2(COMPUTE_CYCLES + 1);

  state_t            state, state_nxt;
  logic [AW-1:0]     idx;
  logic [CW-1:0]     cyc;
  logic [AW-1:0]     elem_q, elem_nxt;
  logic [BW-1:0]     byte_q, byte_nxt;
  logic [BYTE_W-1:0] pk_byte;
  logic              pk_valid, pk_clr;
  logic              load_st, last_wr, nib_acc, hs, last_hs, cyc_last;

  function automatic logic [7:0] acc_byte(input logic [ACC_W-1:0] acc,
                                          input logic [BW-1:0]    k);
    logic [ACC_W-1:0] sh;
    sh = acc >> (8 * k);
    return sh[7:0];
  endfunction

  sa_nibble_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .nib_valid (nib_acc),
    .nib       (host_nib),
    .byte_data (pk_byte),
    .byte_valid(pk_valid)
  );

  assign load_st    = (state == LOAD_W) || (state == LOAD_X);
  assign last_wr    = load_st && pk_valid && (idx == AW'(ELEMS - 1));
  // ready is withheld during the final write strobe so the phase boundary is clean
  assign host_ready = load_st && !last_wr;
  assign nib_acc    = host_valid && host_ready;
  assign arr_data   = DATA_W'(pk_byte);
  assign arr_addr   = idx;
  assign busy       = (state != IDLE);
  assign cyc_last   = (cyc == CW'(COMPUTE_CYCLES - 1));

  assign hs      = (state == READOUT) && res_valid && res_ready;
  assign last_hs = hs && (elem_q == AW'(ELEMS - 1)) && (byte_q == BW'(BPR - 1));

  always_comb begin
    byte_nxt = byte_q + 1'b1;
    elem_nxt = elem_q;
    if (byte_q == BW'(BPR - 1)) begin
      byte_nxt = '0;
      elem_nxt = elem_q + 1'b1;
    end
  end

  // on a handshake the select already points at the next element so its byte loads with no bubble
  assign arr_res_sel = (hs && !last_hs) ? elem_nxt : elem_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    pk_clr         = 1'b0;
    arr_load_w     = 1'b0;
    arr_load_x     = 1'b0;
    arr_clear      = 1'b0;
    arr_compute_en = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = keep_w ? LOAD_X : LOAD_W;
          pk_clr    = 1'b1;
        end
      end
      LOAD_W: begin
        arr_load_w = pk_valid;
        if (last_wr) begin
          state_nxt = LOAD_X;
          pk_clr    = 1'b1;
        end
      end
      LOAD_X: begin
        arr_load_x = pk_valid;
        if (last_wr) begin
          state_nxt = CLEAR;
          pk_clr    = 1'b1;
        end
      end
      CLEAR: begin
        arr_clear = 1'b1;
        state_nxt = COMPUTE;
      end
      COMPUTE: begin
        arr_compute_en = 1'b1;
        if (cyc_last) state_nxt = READOUT;
      end
      READOUT: begin
        if (last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      pk_clr    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      cyc       <= '0;
      elem_q    <= '0;
      byte_q    <= '0;
      res_out   <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      idx       <= '0;
      cyc       <= '0;
      elem_q    <= '0;
      byte_q    <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_hs;
      if (load_st && pk_valid) idx <= last_wr ? '0 : idx + 1'b1;
      if (state == COMPUTE)    cyc <= cyc_last ? '0 : cyc + 1'b1;
      // first READOUT cycle primes the output register; afterwards each handshake refills it
      if (state == READOUT) begin
        if (!res_valid) begin
          res_out   <= acc_byte(arr_res, byte_q);
          res_valid <= 1'b1;
        end else if (res_ready) begin
          if (last_hs) begin
            res_valid <= 1'b0;
            elem_q    <= '0;
            byte_q    <= '0;
          end else begin
            elem_q  <= elem_nxt;
            byte_q  <= byte_nxt;
            res_out <= acc_byte(arr_res, byte_nxt);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sa_sequencer.sv
// Directed, table-driven bench for sa_sequencer with a behavioural 4x4 array model.
module tb_sa_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, keep_w, abort, host_valid, res_ready;
  logic [3:0]  host_nib;
  logic        host_ready, arr_load_w, arr_load_x, arr_clear, arr_compute_en;
  logic [7:0]  arr_data, res_out;
  logic [3:0]  arr_addr, arr_res_sel;
  logic [15:0] arr_res;
  logic        res_valid, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sa_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .keep_w(keep_w), .abort(abort),
    .host_nib(host_nib), .host_valid(host_valid), .host_ready(host_ready),
    .arr_data(arr_data), .arr_addr(arr_addr), .arr_load_w(arr_load_w),
    .arr_load_x(arr_load_x), .arr_clear(arr_clear), .arr_compute_en(arr_compute_en),
    .arr_res_sel(arr_res_sel), .arr_res(arr_res), .res_out(res_out),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done(done)
  );

  // behavioural array: C[r][c] = sum_k X[r][k] * W[k][c]
  logic [7:0]  wmem [16];
  logic [7:0]  xmem [16];
  logic [15:0] accm [16];

  function automatic logic [15:0] mm(input int i);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + 16'(xmem[(i / 4) * 4 + k]) * 16'(wmem[k * 4 + i % 4]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (arr_load_w) wmem[arr_addr] <= arr_data;
    if (arr_load_x) xmem[arr_addr] <= arr_data;
    if (arr_clear) for (int i = 0; i < 16; i++) accm[i] <= '0;
    else if (arr_compute_en) for (int i = 0; i < 16; i++) accm[i] <= mm(i);
  end
  assign arr_res = accm[arr_res_sel];

  // monitor, sampled on the falling edge
  logic [3:0] wa [512];
  logic [7:0] wd [512];
  logic [3:0] xa [512];
  logic [7:0] xd [512];
  logic [7:0] rb [1024];
  int wc = 0, xc = 0, rc = 0, nclr = 0, ndone = 0, nruns = 0, run = 0, last_run = 0;
  int stall_err = 0, done_busy_err = 0;
  logic stall_chk_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_out = '0;

  always @(negedge clk) begin
    if (arr_load_w) begin wa[wc % 512] <= arr_addr; wd[wc % 512] <= arr_data; wc <= wc + 1; end
    if (arr_load_x) begin xa[xc % 512] <= arr_addr; xd[xc % 512] <= arr_data; xc <= xc + 1; end
    if (res_valid && res_ready) begin rb[rc % 1024] <= res_out; rc <= rc + 1; end
    if (arr_clear) nclr <= nclr + 1;
    if (done) ndone <= ndone + 1;
    if (done && busy) done_busy_err <= done_busy_err + 1;
    if (arr_compute_en) run <= run + 1;
    else if (run > 0) begin last_run <= run; nruns <= nruns + 1; run <= 0; end
    if (stall_chk_en && prev_stall && (!res_valid || res_out != prev_out))
      stall_err <= stall_err + 1;
    prev_stall <= res_valid && !res_ready;
    prev_out   <= res_out;
  end

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       keep;
    int         xbase;
    logic [3:0] rdy;
    logic       poke;
    int         exp_w;
    int         exp_x;
    int         exp_comp;
    int         exp_bytes;
  } job_t;

  job_t tbl [4];

  task automatic send_nib(input logic [3:0] n);
    int t = 0;
    host_nib = n;
    host_valid = 1'b1;
    @(negedge clk);
    while (!host_ready && t < 50) begin @(negedge clk); t++; end
    if (!host_ready) check("nib_accept_timeout", host_ready, 1);
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[3:0]);
    send_nib(b[7:4]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_host_ready"}, host_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_strobes"}, {arr_load_w, arr_load_x, arr_clear, arr_compute_en, done}, 0);
  endtask

  task automatic run_job(input job_t j, input string tag);
    int w0, x0, r0, c0, d0, n0, c, bad;
    logic [7:0] e;
    w0 = wc; x0 = xc; r0 = rc; c0 = nclr; d0 = ndone; n0 = nruns;
    @(posedge clk); #1;
    start = 1'b1; keep_w = j.keep;
    @(posedge clk); #1;
    start = 1'b0; keep_w = 1'b0;
    if (!j.keep) for (int i = 0; i < 16; i++) send_byte((i / 4 == i % 4) ? 8'd1 : 8'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(j.xbase + i));
    c = 0;
    stall_chk_en = 1'b1;
    while (rc - r0 < j.exp_bytes && c < 2000) begin
      res_ready = j.rdy[c % 4];
      start = j.poke && (c == 3 || c == 20);
      @(posedge clk); #1;
      c++;
    end
    res_ready = 1'b0; start = 1'b0; stall_chk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_readout_timeout"}, c < 2000, 1);
    check({tag, "_n_load_w"}, wc - w0, j.exp_w);
    check({tag, "_n_load_x"}, xc - x0, j.exp_x);
    check({tag, "_n_clear"}, nclr - c0, 1);
    check({tag, "_n_compute_runs"}, nruns - n0, 1);
    check({tag, "_compute_len"}, last_run, j.exp_comp);
    check({tag, "_n_done"}, ndone - d0, 1);
    check({tag, "_n_bytes"}, rc - r0, j.exp_bytes);
    check({tag, "_busy_after"}, busy, 0);
    bad = 0;
    for (int k = 0; k < j.exp_w; k++)
      if (wa[(w0 + k) % 512] != 4'(k) || wd[(w0 + k) % 512] != ((k / 4 == k % 4) ? 8'd1 : 8'd0)) bad++;
    check({tag, "_w_writes_bad"}, bad, 0);
    bad = 0;
    for (int k = 0; k < j.exp_x; k++)
      if (xa[(x0 + k) % 512] != 4'(k) || xd[(x0 + k) % 512] != 8'(j.xbase + k)) bad++;
    check({tag, "_x_writes_bad"}, bad, 0);
    bad = 0;
    for (int k = 0; k < j.exp_bytes; k++) begin
      e = (k % 2 == 0) ? 8'(j.xbase + k / 2) : 8'd0;
      if (rb[(r0 + k) % 1024] != e) bad++;
    end
    check({tag, "_result_bytes_bad"}, bad, 0);
    check({tag, "_stall_unstable"}, stall_err, 0);
    check({tag, "_done_while_busy"}, done_busy_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t;
    tbl[0] = '{keep: 1'b0, xbase: 1, rdy: 4'b1111, poke: 1'b0, exp_w: 16, exp_x: 16, exp_comp: 10, exp_bytes: 32};
    tbl[1] = '{keep: 1'b0, xbase: 1, rdy: 4'b1001, poke: 1'b0, exp_w: 16, exp_x: 16, exp_comp: 10, exp_bytes: 32};
    tbl[2] = '{keep: 1'b1, xbase: 2, rdy: 4'b1111, poke: 1'b0, exp_w: 0,  exp_x: 16, exp_comp: 10, exp_bytes: 32};
    tbl[3] = '{keep: 1'b0, xbase: 5, rdy: 4'b1111, poke: 1'b1, exp_w: 16, exp_x: 16, exp_comp: 10, exp_bytes: 32};

    rst_n = 1'b0; start = 1'b0; keep_w = 1'b0; abort = 1'b0;
    host_valid = 1'b0; host_nib = '0; res_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset");
    check("reset_data_addr", {arr_data, arr_addr, arr_res_sel, res_out}, 0);

    // nibbles offered while idle must not be taken
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      host_valid = 1'b1; host_nib = 4'hA;
    end
    @(negedge clk);
    check("idle_host_ready", host_ready, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    host_valid = 1'b0;

    for (int i = 0; i < 4; i++) run_job(tbl[i], $sformatf("job%0d", i));

    // abort part-way through LOAD_X, leaving a half byte pending
    d0 = ndone;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'd1);
    for (int i = 0; i < 7; i++) send_nib(4'hF);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_host_ready", host_ready, 0);
    check("abort_strobes", {arr_load_x, arr_clear, arr_compute_en, res_valid}, 0);
    repeat (3) @(negedge clk);
    check("abort_no_done", ndone - d0, 0);
    run_job(tbl[0], "post_abort");

    // reset while a result byte is being held for the consumer
    @(posedge clk); #1;
    start = 1'b1; keep_w = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; keep_w = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(3 + i));
    res_ready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!res_valid && t < 100) begin @(negedge clk); t++; end
    check("rst_mid_res_valid_seen", res_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_quiet("rst_mid");
    check("rst_mid_data", {arr_data, arr_addr, arr_res_sel, res_out}, 0);
    rst_n = 1'b1;
    run_job(tbl[0], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
